// File: rtl/ddram_byte_port_if.sv
// rtl/ddram_byte_port_if.sv - ch1 request/response bus between the byte port and the DDRAM arbiter
interface ddram_byte_port_if;
  logic [27:0] ch1_addr;
  logic [63:0] ch1_din;
  logic        ch1_req;
  logic        ch1_rnw;
  logic        ch1_ready;
  logic [63:0] ch1_dout;

  modport master (
    output ch1_addr, ch1_din, ch1_req, ch1_rnw,
    input  ch1_ready, ch1_dout
  );

  modport slave (
    input  ch1_addr, ch1_din, ch1_req, ch1_rnw,
    output ch1_ready, ch1_dout
  );
endinterface

// File: rtl/ddram_byte_port.sv
// rtl/ddram_byte_port.sv - byte-wide write combiner and reader in front of the ch1 DDRAM port (read cache: DDRAM_BYTE_RDCACHE_EN)
module ddram_byte_port #(
  parameter logic [27:0] BASE_ADDR = 28'h0000000
) (
  input  logic              DDRAM_CLK,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [27:0]       wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              wr_flush,
  input  logic              rd,
  input  logic [27:0]       rd_addr,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              busy,
  ddram_byte_port_if.master ch1
);

  typedef enum logic [2:0] {
    IDLE,
    RMW_ISSUE,
    RMW_WAIT,
    WR_ISSUE,
    WR_WAIT,
    RD_ISSUE,
    RD_WAIT
  } state_t;

  state_t state, state_nxt;

  // Write-combining buffer and the byte parked while an older word is flushed
  logic [63:0] buf_data;
  logic [7:0]  buf_mask;
  logic [24:0] buf_tag;
  logic        pend_valid;
  logic [7:0]  pend_data;
  logic [2:0]  pend_lane;
  logic [24:0] pend_tag;

  // Read queued behind a flush, and the address of the read in flight
  logic        rd_pend;
  logic [27:0] rd_addr_q;

  // Decoded control for this cycle
  logic        dirty;
  logic        wr_in_buf;
  logic [7:0]  merged_mask;
  logic [63:0] merged_data;
  logic [63:0] rmw_word;
  logic [24:0] flush_tag;
  logic [63:0] flush_data;
  logic        cache_hit;
  logic [7:0]  hit_byte;
  logic        do_merge;
  logic        do_pend;
  logic        start_flush;
  logic        flush_full;
  logic        rd_after;
  logic        rd_hit;
  logic        rd_miss;
  logic        rmw_done;
  logic        wr_done;
  logic        rd_done;
  logic        issue_nxt;

  function automatic logic [63:0] put_byte(input logic [63:0] w, input logic [2:0] lane,
                                           input logic [7:0] b);
    logic [63:0] r;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  function automatic logic [27:0] word_addr(input logic [24:0] tag);
    return {tag, 3'b000} + BASE_ADDR;
  endfunction

  assign dirty       = |buf_mask;
  assign wr_in_buf   = !dirty || (buf_tag == wr_addr[27:3]);
  assign merged_mask = buf_mask | (8'b1 << wr_addr[2:0]);
  assign merged_data = put_byte(buf_data, wr_addr[2:0], wr_data);
  assign flush_tag   = do_merge ? wr_addr[27:3] : buf_tag;
  assign flush_data  = do_merge ? merged_data : buf_data;
  assign rmw_done    = (state == RMW_WAIT) && ch1.ch1_ready;
  assign wr_done     = (state == WR_WAIT) && ch1.ch1_ready;
  assign rd_done     = (state == RD_WAIT) && ch1.ch1_ready;
  assign issue_nxt   = (state_nxt == RMW_ISSUE) || (state_nxt == WR_ISSUE) ||
                       (state_nxt == RD_ISSUE);
  assign busy        = (state != IDLE);

`ifdef DDRAM_BYTE_RDCACHE_EN
  logic [63:0] cache_data;
  logic [24:0] cache_tag;
  logic        cache_valid;

  assign cache_hit = cache_valid && (cache_tag == rd_addr[27:3]);
  assign hit_byte  = cache_data[{rd_addr[2:0], 3'b000} +: 8];
`else
  assign cache_hit = 1'b0;
  assign hit_byte  = 8'h00;
`endif

  // Read-modify-write merge: buffered lanes win, the rest come from memory
  always_comb begin
    rmw_word = '0;
    for (int i = 0; i < 8; i++) begin
      rmw_word[i*8 +: 8] = buf_mask[i] ? buf_data[i*8 +: 8] : ch1.ch1_dout[i*8 +: 8];
    end
  end

  // State register
  always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Strobe decode and next state; strobes are only honoured in IDLE
  always_comb begin
    state_nxt   = state;
    do_merge    = 1'b0;
    do_pend     = 1'b0;
    start_flush = 1'b0;
    flush_full  = 1'b0;
    rd_after    = 1'b0;
    rd_hit      = 1'b0;
    rd_miss     = 1'b0;
    case (state)
      IDLE: begin
        if (wr) begin
          if (wr_in_buf) begin
            do_merge = 1'b1;
            if (wr_flush) begin
              start_flush = 1'b1;
              flush_full  = (merged_mask == 8'hFF);
            end
          end else begin
            do_pend     = 1'b1;
            start_flush = 1'b1;
            flush_full  = (buf_mask == 8'hFF);
          end
        end else if (rd) begin
          if (dirty) begin
            start_flush = 1'b1;
            flush_full  = (buf_mask == 8'hFF);
            rd_after    = 1'b1;
          end else if (cache_hit) begin
            rd_hit = 1'b1;
          end else begin
            rd_miss = 1'b1;
          end
        end else if (wr_flush && dirty) begin
          start_flush = 1'b1;
          flush_full  = (buf_mask == 8'hFF);
        end
        if (start_flush) begin
          state_nxt = flush_full ? WR_ISSUE : RMW_ISSUE;
        end else if (rd_miss) begin
          state_nxt = RD_ISSUE;
        end
      end
      RMW_ISSUE: state_nxt = RMW_WAIT;
      RMW_WAIT:  if (ch1.ch1_ready) state_nxt = WR_ISSUE;
      WR_ISSUE:  state_nxt = WR_WAIT;
      WR_WAIT:   if (ch1.ch1_ready) state_nxt = rd_pend ? RD_ISSUE : IDLE;
      RD_ISSUE:  state_nxt = RD_WAIT;
      RD_WAIT:   if (ch1.ch1_ready) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Write buffer: merge bytes, park a conflicting byte, reload it after the old word is written
  always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
    if (!reset_n) begin
      buf_data   <= '0;
      buf_mask   <= '0;
      buf_tag    <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_lane  <= '0;
      pend_tag   <= '0;
    end else begin
      if (do_merge) begin
        buf_data <= merged_data;
        buf_mask <= merged_mask;
        buf_tag  <= wr_addr[27:3];
      end
      if (do_pend) begin
        pend_valid <= 1'b1;
        pend_data  <= wr_data;
        pend_lane  <= wr_addr[2:0];
        pend_tag   <= wr_addr[27:3];
      end
      if (rmw_done) begin
        buf_data <= rmw_word;
      end
      if (wr_done) begin
        if (pend_valid) begin
          buf_data   <= put_byte(64'd0, pend_lane, pend_data);
          buf_mask   <= 8'b1 << pend_lane;
          buf_tag    <= pend_tag;
          pend_valid <= 1'b0;
        end else begin
          buf_mask <= '0;
        end
      end
    end
  end

  // ch1 request registers; held steady from the request cycle until ch1_ready
  always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
    if (!reset_n) begin
      ch1.ch1_req  <= 1'b0;
      ch1.ch1_rnw  <= 1'b1;
      ch1.ch1_addr <= '0;
      ch1.ch1_din  <= '0;
      rd_pend      <= 1'b0;
      rd_addr_q    <= '0;
    end else begin
      ch1.ch1_req <= issue_nxt;
      if (start_flush) begin
        ch1.ch1_addr <= word_addr(flush_tag);
        ch1.ch1_din  <= flush_data;
        ch1.ch1_rnw  <= !flush_full;
      end
      if (rd_miss) begin
        ch1.ch1_addr <= word_addr(rd_addr[27:3]);
        ch1.ch1_rnw  <= 1'b1;
      end
      if (rd_after || rd_miss) begin
        rd_addr_q <= rd_addr;
      end
      if (rd_after) begin
        rd_pend <= 1'b1;
      end
      if (rmw_done) begin
        ch1.ch1_din <= rmw_word;
        ch1.ch1_rnw <= 1'b0;
      end
      if (wr_done && rd_pend) begin
        ch1.ch1_addr <= word_addr(rd_addr_q[27:3]);
        ch1.ch1_rnw  <= 1'b1;
        rd_pend      <= 1'b0;
      end
    end
  end

  // Read return path and the one-word cache that shadows the last word read
  always_ff @(posedge DDRAM_CLK or negedge reset_n) begin
    if (!reset_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
`ifdef DDRAM_BYTE_RDCACHE_EN
      cache_data  <= '0;
      cache_tag   <= '0;
      cache_valid <= 1'b0;
`endif
    end else begin
      rd_valid <= 1'b0;
      if (rd_hit) begin
        rd_data  <= hit_byte;
        rd_valid <= 1'b1;
      end
      if (rd_done) begin
        rd_data  <= ch1.ch1_dout[{rd_addr_q[2:0], 3'b000} +: 8];
        rd_valid <= 1'b1;
`ifdef DDRAM_BYTE_RDCACHE_EN
        cache_data  <= ch1.ch1_dout;
        cache_tag   <= rd_addr_q[27:3];
        cache_valid <= 1'b1;
`endif
      end
`ifdef DDRAM_BYTE_RDCACHE_EN
      if (wr_done && (cache_tag == buf_tag)) begin
        cache_valid <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ddram_byte_port.sv
// tb/tb_ddram_byte_port.sv - randomized and directed bench for ddram_byte_port against a byte-level memory model
module tb_ddram_byte_port;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr = 1'b0;
  logic [27:0] wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        wr_flush = 1'b0;
  logic        rd = 1'b0;
  logic [27:0] rd_addr = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        busy;

  always #5 clk = ~clk;

  ddram_byte_port_if ch1();

  ddram_byte_port dut (
    .DDRAM_CLK(clk),
    .reset_n  (reset_n),
    .wr       (wr),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_flush (wr_flush),
    .rd       (rd),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .ch1      (ch1)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory image: words written through ch1 over an initial image
  logic [63:0] mem [logic [24:0]];
  logic [63:0] pre [logic [24:0]];
  // Reference: every byte ever written by the requester, by byte address
  logic [7:0]  ref_bytes [logic [27:0]];

  function automatic logic [63:0] init_word(input logic [24:0] t);
    if (pre.exists(t)) return pre[t];
    return {t, t[6:0] ^ 7'h55, ~t, t[6:0]};
  endfunction

  function automatic logic [63:0] mem_word(input logic [24:0] t);
    if (mem.exists(t)) return mem[t];
    return init_word(t);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [27:0] a);
    logic [63:0] w;
    if (ref_bytes.exists(a)) return ref_bytes[a];
    w = init_word(a[27:3]);
    return w[{a[2:0], 3'b000} +: 8];
  endfunction

  typedef struct {
    logic        rnw;
    logic [27:0] addr;
    logic [63:0] din;
  } txn_t;
  txn_t log_q[$];

  logic        mdl_ready = 1'b0;
  logic [63:0] mdl_dout = '0;
  logic        late_ready = 1'b0;
  logic        model_off = 1'b0;

  assign ch1.ch1_ready = mdl_ready | late_ready;
  assign ch1.ch1_dout  = late_ready ? 64'hDEADBEEF0BADF00D : mdl_dout;

  // Arbiter model: accepts each request, checks the request stays put, answers after 1-4 cycles
  initial begin
    txn_t t;
    forever begin
      @(posedge clk);
      #1;
      mdl_ready = 1'b0;
      if (ch1.ch1_req && !model_off && reset_n) begin
        t.rnw  = ch1.ch1_rnw;
        t.addr = ch1.ch1_addr;
        t.din  = ch1.ch1_din;
        log_q.push_back(t);
        check("addr_aligned", {61'd0, t.addr[2:0]}, 64'd0);
        repeat ($urandom_range(1, 4)) begin
          @(posedge clk);
          #1;
          check("req_single", {63'd0, ch1.ch1_req}, 64'd0);
          check("addr_stable", {36'd0, ch1.ch1_addr}, {36'd0, t.addr});
          check("din_stable", ch1.ch1_din, t.din);
          check("rnw_stable", {63'd0, ch1.ch1_rnw}, {63'd0, t.rnw});
        end
        if (t.rnw) mdl_dout = mem_word(t.addr[27:3]);
        else mem[t.addr[27:3]] = t.din;
        mdl_ready = 1'b1;
      end
    end
  end

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("idle_in_time", {63'd0, busy}, 64'd0);
  endtask

  task automatic do_wr(input logic [27:0] a, input logic [7:0] d, input logic fl,
                       output logic busy_after);
    wr = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_flush = fl;
    ref_bytes[a] = d;
    @(negedge clk);
    wr = 1'b0;
    wr_flush = 1'b0;
    busy_after = busy;
    wait_idle();
  endtask

  task automatic do_flush();
    wr_flush = 1'b1;
    @(negedge clk);
    wr_flush = 1'b0;
    wait_idle();
  endtask

  task automatic do_rd(input logic [27:0] a, output int lat);
    int k;
    rd = 1'b1;
    rd_addr = a;
    @(negedge clk);
    rd = 1'b0;
    k = 0;
    while (!rd_valid && k < 500) begin
      @(negedge clk);
      k++;
    end
    lat = k;
    check("rd_valid_seen", {63'd0, rd_valid}, 64'd1);
    check($sformatf("rd_data@%0h", a), {56'd0, rd_data}, {56'd0, ref_byte(a)});
    wait_idle();
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_req"}, {63'd0, ch1.ch1_req}, 64'd0);
    check({pfx, "_rnw"}, {63'd0, ch1.ch1_rnw}, 64'd1);
    check({pfx, "_addr"}, {36'd0, ch1.ch1_addr}, 64'd0);
    check({pfx, "_din"}, ch1.ch1_din, 64'd0);
    check({pfx, "_rd_data"}, {56'd0, rd_data}, 64'd0);
    check({pfx, "_rd_valid"}, {63'd0, rd_valid}, 64'd0);
    check({pfx, "_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        b;
    int          lat;
    logic [63:0] w;
    logic [27:0] a;
    int          op;

    pre[25'h040] = 64'hFFEEDDCCBBAA9988;
    pre[25'h080] = 64'h0706050403020100;

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Full-word write
    log_q.delete();
    for (int i = 0; i < 8; i++) begin
      do_wr(28'h100 + 28'(i), 8'(8'h11 * (i + 1)), 1'b0, b);
      check("merge_not_busy", {63'd0, b}, 64'd0);
    end
    check("merge_no_traffic", 64'(log_q.size()), 64'd0);
    do_flush();
    check("full_txn_count", 64'(log_q.size()), 64'd1);
    if (log_q.size() == 1) begin
      check("full_rnw", {63'd0, log_q[0].rnw}, 64'd0);
      check("full_addr", {36'd0, log_q[0].addr}, 64'h100);
      check("full_din", log_q[0].din, 64'h8877665544332211);
    end

    // Partial flush with read-modify-write
    log_q.delete();
    do_wr(28'h203, 8'hAB, 1'b0, b);
    do_flush();
    check("rmw_txn_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      check("rmw_rd_rnw", {63'd0, log_q[0].rnw}, 64'd1);
      check("rmw_rd_addr", {36'd0, log_q[0].addr}, 64'h200);
      check("rmw_wr_rnw", {63'd0, log_q[1].rnw}, 64'd0);
      check("rmw_wr_addr", {36'd0, log_q[1].addr}, 64'h200);
      check("rmw_wr_din", log_q[1].din, 64'hFFEEDDCCABAA9988);
    end

    // Tag change flushes the old word and keeps only the new byte
    log_q.delete();
    do_wr(28'h300, 8'h01, 1'b0, b);
    check("tag_first_not_busy", {63'd0, b}, 64'd0);
    do_wr(28'h308, 8'h02, 1'b0, b);
    check("tag_change_busy", {63'd0, b}, 64'd1);
    check("tag_txn_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      w = init_word(25'h060);
      w[7:0] = 8'h01;
      check("tag_rd_addr", {36'd0, log_q[0].addr}, 64'h300);
      check("tag_wr_din", log_q[1].din, w);
    end
    log_q.delete();
    do_flush();
    check("reload_txn_count", 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      w = init_word(25'h061);
      w[7:0] = 8'h02;
      check("reload_addr", {36'd0, log_q[1].addr}, 64'h308);
      check("reload_din", log_q[1].din, w);
    end

    // Read miss, then a second read of the same word
    log_q.delete();
    do_rd(28'h405, lat);
    check("miss_byte", {56'd0, rd_data}, 64'h05);
    check("miss_txn_count", 64'(log_q.size()), 64'd1);
    do_rd(28'h402, lat);
    check("second_byte", {56'd0, rd_data}, 64'h02);
`ifdef DDRAM_BYTE_RDCACHE_EN
    check("hit_latency", 64'(lat), 64'd0);
    check("hit_no_traffic", 64'(log_q.size()), 64'd1);
`else
    check("nocache_second_read", 64'(log_q.size()), 64'd2);
`endif

    // Coherency: a buffered write to the cached word forces flush then fresh read
    log_q.delete();
    do_wr(28'h401, 8'hEE, 1'b0, b);
    do_rd(28'h401, lat);
    check("coh_byte", {56'd0, rd_data}, 64'hEE);
    check("coh_txn_count", 64'(log_q.size()), 64'd3);
    if (log_q.size() == 3) begin
      check("coh_last_rnw", {63'd0, log_q[2].rnw}, 64'd1);
      check("coh_last_addr", {36'd0, log_q[2].addr}, 64'h400);
    end

    // Reset in the middle of a read; a stale completion arrives afterwards
    model_off = 1'b1;
    rd = 1'b1;
    rd_addr = 28'h123;
    @(negedge clk);
    rd = 1'b0;
    check("abort_req_seen", {63'd0, ch1.ch1_req}, 64'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_values("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    late_ready = 1'b1;
    @(negedge clk);
    late_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stale_no_valid", {63'd0, rd_valid}, 64'd0);
      @(negedge clk);
    end
    check_reset_values("after_stale");
    model_off = 1'b0;
    log_q.delete();
    do_rd(28'h123, lat);
    check("post_reset_read", 64'(log_q.size()), 64'd1);

    // Randomized traffic over a small window of words
    for (int n = 0; n < 300; n++) begin
      a = 28'($urandom_range(0, 63)) + 28'h0800;
      op = int'($urandom_range(0, 9));
      if (op < 5) begin
        do_wr(a, 8'($urandom), ($urandom_range(0, 4) == 0), b);
      end else if (op < 8) begin
        do_rd(a, lat);
      end else begin
        do_flush();
      end
    end
    do_flush();
    for (int t = 0; t < 8; t++) begin
      w = mem_word(25'h100 + 25'(t));
      for (int l = 0; l < 8; l++) begin
        a = 28'h0800 + 28'(t * 8 + l);
        check($sformatf("final_mem@%0h", a), {56'd0, w[l*8 +: 8]}, {56'd0, ref_byte(a)});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddram_byte_port.md
# ddram_byte_port

Byte-wide front end for the single-channel DDRAM arbiter (`ch1_*` port). It turns 8-bit ROM/asset download writes and 8-bit core reads into 64-bit `ch1` transactions:
- Writes are combined into one 64-bit buffer, using read-modify-write for partial words.
- Reads are served from an optional one-word read cache.

It sits directly upstream of the DDRAM arbiter and is the only `ch1` requester.

## Interface
Parameters:
- `BASE_ADDR`, default `28'h0000000`: byte offset added to `wr_addr`/`rd_addr` before driving `ch1_addr`; bits [2:0] must be 0.

Ports:
- `DDRAM_CLK` in 1: the only clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr` in 1: byte write strobe; accepted only when `busy`=0.
- `wr_addr` in 28: byte address of the write.
- `wr_data` in 8: write byte.
- `wr_flush` in 1: commit the write buffer; accepted only when `busy`=0.
- `rd` in 1: byte read strobe; accepted only when `busy`=0 and `wr`=0.
- `rd_addr` in 28: byte address of the read.
- `rd_data` out 8: read byte; valid while `rd_valid`=1.
- `rd_valid` out 1: one-cycle pulse marking `rd_data` valid.
- `busy` out 1: high while any `ch1` transaction or flush is in progress.
- `ch1_addr` out 28: word address to arbiter; bits [2:0] always 0.
- `ch1_din` out 64: write word to arbiter.
- `ch1_req` out 1: one-cycle request pulse.
- `ch1_rnw` out 1: 1 = read, 0 = write.
- `ch1_ready` in 1: completion pulse from arbiter.
- `ch1_dout` in 64: read word from arbiter; valid while `ch1_ready`=1 on reads.

## Operation
- Byte lane: byte address bits [2:0] select lane n = bits [8n+7:8n] of the 64-bit word (little-endian).
- Word tag: address bits [27:3].
- Write buffer: 64-bit data, 8-bit byte mask, and a word tag; it is dirty when the mask is nonzero.
- `wr` with the buffer clean or with a matching tag: merge the byte and set its mask bit; no `ch1` traffic; `busy` stays 0.
- `wr` with the buffer dirty and a different tag: hold the byte in a pending register and flush the old word. After `WR_WAIT`, the buffer reloads with only the pending byte.
- `wr_flush` with the buffer dirty starts a flush. With the buffer clean it is a no-op.
- A simultaneous `wr` and `wr_flush` merges the byte first, then flushes.
- Flush, full mask (`8'hFF`): `WR_ISSUE` then `WR_WAIT`.
- Flush, partial mask: `RMW_ISSUE` reads the word, then `RMW_WAIT`. On `ch1_ready`, unmasked lanes take `ch1_dout` and masked lanes keep buffered bytes, then `WR_ISSUE`.
- `rd` with the buffer dirty: flush first, then perform the read. A read never bypasses buffered data.
- `rd` miss: `RD_ISSUE` then `RD_WAIT`. On `ch1_ready`, output lane `rd_addr[2:0]` of `ch1_dout` with a `rd_valid` pulse; the cache loads the word.
- Any completed write to a word whose tag equals the cache tag invalidates the cache.
- State machine: `IDLE`, `RMW_ISSUE`, `RMW_WAIT`, `WR_ISSUE`, `WR_WAIT`, `RD_ISSUE`, `RD_WAIT`. Each `*_ISSUE` state lasts one cycle and drives `ch1_req`=1. Each `*_WAIT` state holds until `ch1_ready`.
- `ch1_ready` received in `IDLE` is ignored; this covers a stale completion after reset.
- Strobes arriving while `busy`=1 are ignored. The requester must not issue them.

## Timing
- Reset values:
  - `ch1_req`=0, `ch1_rnw`=1, `ch1_addr`=0, `ch1_din`=0.
  - `rd_data`=0, `rd_valid`=0, `busy`=0.
  - Buffer mask=0, cache invalid, state `IDLE`.
- `busy` rises in the cycle after the triggering strobe and falls in the cycle after the final `ch1_ready`.
- `ch1_addr`, `ch1_din` and `ch1_rnw` are registered and stable from the `ch1_req` cycle until `ch1_ready`.
- `ch1_req` is asserted exactly one cycle per transaction and is never re-asserted before `ch1_ready`.
- Read hit: `rd_valid` in cycle N+1 after `rd` in cycle N.
- Read miss: `ch1_req` in cycle N+1; `rd_valid` in the cycle after `ch1_ready`.
- Write-only merge: zero `ch1` traffic and zero added latency.
- Reset asserted mid-transaction: immediate return to reset values; the pending byte and the buffer are discarded.

## Configuration
- `DDRAM_BYTE_RDCACHE_EN` defined: the one-word read cache (64-bit data, tag, valid bit) is present. A `rd` whose tag matches a valid cache entry and finds the buffer clean is a hit, answered in 1 cycle with no `ch1` traffic.
- `DDRAM_BYTE_RDCACHE_EN` undefined: no cache. Every `rd` is a miss and issues a `ch1` read; invalidation logic is absent.

## Test plan
- Full-word write: write 8 bytes `0x11..0x88` to `0x100..0x107`, then `wr_flush` -> exactly one `ch1` write with `ch1_addr`=`0x100`, `ch1_din`=`64'h8877665544332211`, `ch1_rnw`=0, and no read beforehand.
- Partial flush: write `0xAB` to `0x203`, then flush; the memory model returns `64'hFFEEDDCCBBAA9988` -> one read of `0x200`, then one write of `64'hFFEEDDCCABAA9988`.
- Tag change: write `0x01` at `0x300`, then `0x02` at `0x308` -> RMW flush of `0x300` with `busy`=1; afterwards the buffer holds only lane 0 = `0x02` with tag `0x308>>3`.
- Read miss then hit (with the macro defined): `rd 0x405` with memory word `64'h0706050403020100` -> `rd_data`=`0x05` after `ch1_ready`. Then `rd 0x402` -> `rd_data`=`0x02` on the next cycle with no `ch1_req`. Without the macro, the second read issues a `ch1` read.
- Coherency: the cache holds `0x400`; write `0xEE` at `0x401`, then `rd 0x401` -> flush first, then a fresh read, `rd_data`=`0xEE`.
- Reset mid-read: drop `reset_n` during `RD_WAIT` and release it; a late `ch1_ready` arrives -> `rd_valid` stays 0, all outputs hold reset values, and the next `rd` behaves normally.
